// File: rtl/block_packer.sv
// Word-serial packer: gathers BUS_W-bit words into one Nbits-bit block with per-byte
// validity, applies 0x01 padding to short final blocks and hands the block downstream.
module block_packer #(
    parameter int Nbits = 128,
    parameter int BUS_W = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ctrl_pad_en,
    input  logic [BUS_W-1:0]              in_data,
    input  logic [$clog2(BUS_W/8):0]      in_nbytes,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [Nbits-1:0]              out_block,
    output logic [Nbits/8-1:0]            out_block_validity,
    output logic                          out_last,
    output logic                          out_padded,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int NWORDS = Nbits / BUS_W;
    localparam int NLANES = BUS_W / 8;
    localparam int NBYTES = Nbits / 8;
    localparam int NB_W   = $clog2(NLANES) + 1;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int P_W    = $clog2(NBYTES + 1);

    typedef enum logic [0:0] {FILL, FULL} state_t;

    state_t             state;
    logic [CNT_W-1:0]   word_cnt;
    logic [NB_W-1:0]    lanes;
    logic [NLANES-1:0]  lane_ok;
    logic [BUS_W-1:0]   word_masked;
    logic [P_W-1:0]     pos;
    logic               pad_hit;
    logic               closing;
    logic [Nbits-1:0]   blk_next;
    logic [NBYTES-1:0]  val_next;

    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);

    // Next block image for an accepted word: masked word in its slot, plus the pad byte
    // placed at the first unused byte position when the message ends short.
    always_comb begin
        lanes = in_nbytes;
        if (!in_last || (in_nbytes > NB_W'(NLANES)))
            lanes = NB_W'(NLANES);

        lane_ok     = '0;
        word_masked = '0;
        for (int unsigned j = 0; j < NLANES; j++) begin
            lane_ok[j] = (NB_W'(j) < lanes);
            word_masked[8*j +: 8] = lane_ok[j] ? in_data[8*j +: 8] : 8'h00;
        end

        pos     = P_W'(word_cnt) * P_W'(NLANES) + P_W'(lanes);
        pad_hit = in_last && (pos < P_W'(NBYTES));
        closing = in_last || (word_cnt == CNT_W'(NWORDS - 1));

        blk_next = out_block;
        val_next = out_block_validity;
        for (int unsigned w = 0; w < NWORDS; w++) begin
            if (CNT_W'(w) == word_cnt) begin
                blk_next[BUS_W*w +: BUS_W]  = word_masked;
                val_next[NLANES*w +: NLANES] = lane_ok;
            end
        end

        if (pad_hit && ctrl_pad_en) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
                if (P_W'(i) == pos)
                    blk_next[8*i +: 8] = 8'h01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= FILL;
            word_cnt           <= '0;
            out_block          <= '0;
            out_block_validity <= '0;
            out_last           <= 1'b0;
            out_padded         <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        out_block          <= blk_next;
                        out_block_validity <= val_next;
                        if (closing) begin
                            state      <= FULL;
                            word_cnt   <= '0;
                            out_last   <= in_last;
                            out_padded <= pad_hit;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state              <= FILL;
                        out_block          <= '0;
                        out_block_validity <= '0;
                        out_last           <= 1'b0;
                        out_padded         <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_block_packer.sv
// Bench for block_packer: byte-level reference model feeds a scoreboard of expected
// blocks; directed cases from the test plan plus a randomised message run.
module tb_block_packer;

    localparam int NL     = 4;
    localparam int NW     = 4;
    localparam int NBYTES = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ctrl_pad_en;
    logic [31:0]  in_data;
    logic [2:0]   in_nbytes;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_block;
    logic [15:0]  out_block_validity;
    logic         out_last;
    logic         out_padded;
    logic         out_valid;
    logic         out_ready;

    typedef struct packed {
        logic [127:0] blk;
        logic [15:0]  val;
        logic         last;
        logic         padded;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mb[NBYTES];
    logic [15:0] mv;
    int          mcnt;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          rnd_bp   = 1'b0;

    block_packer #(.Nbits(128), .BUS_W(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ctrl_pad_en       (ctrl_pad_en),
        .in_data           (in_data),
        .in_nbytes         (in_nbytes),
        .in_last           (in_last),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_block         (out_block),
        .out_block_validity(out_block_validity),
        .out_last          (out_last),
        .out_padded        (out_padded),
        .out_valid         (out_valid),
        .out_ready         (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
        mv   = '0;
        mcnt = 0;
    endtask

    task automatic model_accept(input logic [31:0] d, input bit last, input int nb, input bit pad);
        int   lanes;
        int   p;
        exp_t e;
        lanes = last ? ((nb > NL) ? NL : nb) : NL;
        for (int j = 0; j < NL; j++) begin
            if (j < lanes) begin
                mb[mcnt*NL + j] = d[8*j +: 8];
                mv[mcnt*NL + j] = 1'b1;
            end else begin
                mb[mcnt*NL + j] = 8'h00;
            end
        end
        p = mcnt*NL + lanes;
        if (last || mcnt == NW-1) begin
            e.padded = (p < NBYTES);
            if (e.padded && pad) mb[p] = 8'h01;
            for (int i = 0; i < NBYTES; i++) e.blk[8*i +: 8] = mb[i];
            e.val  = mv;
            e.last = last;
            sb.push_back(e);
            model_reset();
        end else begin
            mcnt++;
        end
    endtask

    // Called away from the falling edge; returns just after the accepting rising edge.
    task automatic send_word(input logic [31:0] d, input bit last, input int nb);
        bit ok = 1'b0;
        in_data   = d;
        in_last   = last;
        in_nbytes = 3'(nb);
        in_valid  = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                model_accept(d, last, nb, ctrl_pad_en);
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) check_eq("accept_timeout", {127'b0, in_ready}, 128'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_block", {127'b0, out_valid}, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("sb_block",    out_block,                   e.blk);
                check_eq("sb_validity", {112'b0, out_block_validity}, {112'b0, e.val});
                check_eq("sb_last",     {127'b0, out_last},          {127'b0, e.last});
                check_eq("sb_padded",   {127'b0, out_padded},        {127'b0, e.padded});
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ctrl_pad_en = 1'b0; in_data = '0; in_nbytes = '0;
        in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        model_reset();

        @(negedge clk);
        check_eq("rst_in_ready",  {127'b0, in_ready},  128'd1);
        check_eq("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check_eq("rst_block",     out_block,           128'd0);
        check_eq("rst_validity",  {112'b0, out_block_validity}, 128'd0);
        check_eq("rst_flags",     {126'b0, out_last, out_padded}, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Full block, no last
        send_word(32'h03020100, 0, 0);
        send_word(32'h07060504, 0, 0);
        send_word(32'h0B0A0908, 0, 0);
        send_word(32'h0F0E0D0C, 0, 0);
        @(negedge clk);
        check_eq("full_valid", {127'b0, out_valid}, 128'd1);
        check_eq("full_block", out_block, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        check_eq("full_vld",   {112'b0, out_block_validity}, 128'hFFFF);
        @(negedge clk);
        check_eq("full_valid_1cyc", {127'b0, out_valid}, 128'd0);
        @(posedge clk); #1;

        // Partial last word with padding
        ctrl_pad_en = 1'b1;
        send_word(32'h33221100, 0, 0);
        send_word(32'hDDCCBBAA, 1, 2);
        @(negedge clk);
        check_eq("part_block", out_block, 128'h0001BBAA33221100);
        check_eq("part_vld",   {112'b0, out_block_validity}, 128'h003F);
        check_eq("part_flags", {126'b0, out_last, out_padded}, 128'd3);
        @(posedge clk); #1;

        // Empty message, pad on then off
        send_word(32'hDEADBEEF, 1, 0);
        @(negedge clk);
        check_eq("empty_pad_block", out_block, 128'h1);
        @(posedge clk); #1;
        ctrl_pad_en = 1'b0;
        send_word(32'hDEADBEEF, 1, 0);
        @(negedge clk);
        check_eq("empty_nopad_block", out_block, 128'h0);
        check_eq("empty_flags", {126'b0, out_last, out_padded}, 128'd3);
        @(posedge clk); #1;

        // Backpressure: block held while a word waits at the input
        ctrl_pad_en = 1'b1;
        out_ready   = 1'b0;
        send_word(32'hA3A2A1A0, 0, 0);
        send_word(32'hB3B2B1B0, 0, 0);
        send_word(32'hC3C2C1C0, 0, 0);
        send_word(32'hD3D2D1D0, 0, 0);
        in_data = 32'hE3E2E1E0; in_last = 1'b1; in_nbytes = 3'd3; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("bp_in_ready",  {127'b0, in_ready},  128'd0);
            check_eq("bp_out_valid", {127'b0, out_valid}, 128'd1);
            check_eq("bp_block", out_block, 128'hD3D2D1D0_C3C2C1C0_B3B2B1B0_A3A2A1A0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send_word(32'hE3E2E1E0, 1, 3);
        @(negedge clk);
        check_eq("bp_held_block", out_block, 128'h01E2E1E0);
        check_eq("bp_held_vld",   {112'b0, out_block_validity}, 128'h0007);
        @(posedge clk); #1;

        // Exact-fit last block
        send_word(32'h11111111, 0, 0);
        send_word(32'h22222222, 0, 0);
        send_word(32'h33333333, 0, 0);
        send_word(32'h44444444, 1, 4);
        @(negedge clk);
        check_eq("exact_flags", {126'b0, out_last, out_padded}, 128'd2);
        check_eq("exact_block", out_block, 128'h44444444_33333333_22222222_11111111);
        @(posedge clk); #1;

        // Over-range in_nbytes is clamped to a full word
        send_word(32'h99887766, 1, 7);
        @(negedge clk);
        check_eq("clamp_block", out_block, 128'h01_99887766);
        @(posedge clk); #1;

        // Reset mid-block drops partial content
        send_word(32'hAAAAAAAA, 0, 0);
        send_word(32'hBBBBBBBB, 0, 0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_eq("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        send_word(32'h44332211, 1, 4);
        @(negedge clk);
        check_eq("midrst_block", out_block, 128'h01_44332211);
        check_eq("midrst_vld",   {112'b0, out_block_validity}, 128'h000F);
        @(posedge clk); #1;

        // Random messages with random output backpressure
        rnd_bp = 1'b1;
        for (int m = 0; m < 25; m++) begin
            int nwords;
            nwords = $urandom_range(1, 7);
            ctrl_pad_en = $urandom_range(0, 1);
            for (int w = 0; w < nwords; w++) begin
                if (w == nwords - 1)
                    send_word($urandom, 1, $urandom_range(0, 5));
                else
                    send_word($urandom, 0, 0);
            end
        end
        rnd_bp = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(posedge clk); #2;
        end
        check_eq("sb_drained", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_packer.md
Name: block_packer

Overview:
- Upstream neighbour of the digestion stage. Collects BUS_W-bit words from the input data interface into one Nbits-bit block with per-byte validity.
- Applies Spook-style 0x01 padding to partial final blocks.
- Presents the finished block and validity vector to the digestion stage over a valid/ready handshake.
- Word-serial input, one buffered block, no bypass path.

Parameters:
- Nbits, 128, block width in bits. Must be a multiple of BUS_W.
- BUS_W, 32, input word width in bits. Must be a multiple of 8.
- Derived: NWORDS = Nbits/BUS_W; NLANES = BUS_W/8; NBYTES = Nbits/8.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ctrl_pad_en  in  1  enables insertion of the 0x01 pad byte. Sampled when the last word is accepted.
- in_data  in  BUS_W  input word. Byte lane j is bits [8j+7:8j].
- in_nbytes  in  $clog2(NLANES)+1  number of valid low lanes in a last word (0..NLANES). Ignored when in_last=0.
- in_last  in  1  word is the final word of the message.
- in_valid  in  1  input word present.
- in_ready  out  1  packer can accept a word.
- out_block  out  Nbits  packed block. Block byte i is bits [8i+7:8i].
- out_block_validity  out  NBYTES  bit i = 1 when block byte i holds message data.
- out_last  out  1  block is the final block of the message.
- out_padded  out  1  block holds fewer than NBYTES valid bytes.
- out_valid  out  1  block available.
- out_ready  in  1  downstream consumes the block.

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, word_cnt=0.
  - Block register and validity cleared to 0.
  - out_valid, out_last and out_padded are 0.
  - in_ready=1 (derived from state), but no transfer is taken while rst_n=0.
  - Reset mid-block discards all partial content.
- State machine:
  - FILL: in_ready=1, out_valid=0.
  - FULL: in_ready=0, out_valid=1.
- Accept in FILL on in_valid & in_ready:
  - Word written into slot word_cnt, i.e. block bits [BUS_W*(word_cnt+1)-1 : BUS_W*word_cnt], first word in the least-significant slot.
- Lane masking:
  - If in_last=0, all NLANES lanes are valid.
  - If in_last=1, lanes < in_nbytes are valid. Lanes >= in_nbytes are stored as 0x00 regardless of in_data, with validity 0.
  - in_nbytes > NLANES is treated as NLANES.
- Transitions:
  - In FILL, word_cnt increments after each accept.
  - FILL -> FULL when the accepted word has in_last=1 or word_cnt==NWORDS-1. word_cnt returns to 0.
  - out_valid rises the cycle after the accept. Latency from the final accept to out_valid is 1 cycle.
- Last block:
  - out_last=1 iff the block was closed by in_last.
  - A full block closed by word_cnt==NWORDS-1 without in_last has out_last=0.
  - Unfilled slots after in_last remain 0x00 with validity 0.
- Padding:
  - Let p = word_cnt*NLANES + valid lanes of the last word.
  - If p < NBYTES, out_padded=1.
  - If p < NBYTES and ctrl_pad_en=1, block byte p = 0x01. Its validity bit stays 0.
  - If p == NBYTES, no pad byte is inserted and out_padded=0.
- Empty final word: in_last=1 with in_nbytes=0 is legal and contributes no data.
  - At word_cnt=0 this yields an all-zero block, byte0=0x01 if padding is enabled, validity all 0, out_last=1, out_padded=1.
- Output handshake:
  - FULL holds out_* stable until out_valid & out_ready.
  - On that edge: state -> FILL, block/validity/flags cleared, out_valid=0 next cycle.
- Throughput: a full block needs NWORDS accepts plus at least 1 output cycle, with no input/output overlap.
- Simultaneous events: in FULL, input is not accepted (in_ready=0) even if in_valid=1. The word is retained by the source.
- Flag behaviour in FULL: out_last and out_padded are valid only while out_valid=1 and are 0 otherwise.

Test Plan:
- Full block: after reset, feed 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with in_last=0 and out_ready=1.
  - out_block=0x0F0E...0100 one cycle after the 4th accept.
  - validity=0xFFFF, out_last=0, out_padded=0, out_valid high exactly 1 cycle.
- Partial last word: words 0x33221100 then 0xDDCCBBAA with in_last=1, in_nbytes=2, ctrl_pad_en=1.
  - block bytes 0..5 = 00 11 22 33 AA BB, byte6=0x01, rest 0.
  - validity=0x003F, out_last=1, out_padded=1.
- Empty message: single word, in_last=1, in_nbytes=0, ctrl_pad_en=1.
  - out_block=0x...0001, validity=0x0000, out_last=1, out_padded=1.
  - Repeat with ctrl_pad_en=0 -> out_block=0.
- Backpressure: complete a block with out_ready=0 for 5 cycles while in_valid=1.
  - in_ready=0 and out_* stable throughout.
  - No word lost; the next block starts with the held word after out_ready=1.
- Exact-fit last: 4 full words, last with in_last=1 and in_nbytes=4 -> out_last=1, out_padded=0, no 0x01 byte.
- Reset mid-block: assert rst_n=0 after 2 accepts, release, then feed a 1-word last block (in_nbytes=4).
  - Block holds only the new word, validity=0x000F, byte4=0x01 with padding enabled.
